// File: rtl/snn_ff_pkg.sv
// Shared constants for the snn_ff weight-update path.
// Sized for the neg_derivative ROM and the learning-lane count.
package snn_ff_pkg;

  localparam int ROM_ADDR_WIDTH  = 8;
  localparam int ROM_DATA_WIDTH  = 8;
  localparam int NUM_LEARN_LANES = 4;

endpackage

// File: rtl/snn_ff_sync_fifo.sv
// Show-ahead synchronous FIFO with an occupancy count.
// Accepts a write while full if the same cycle pops; a pop while empty is ignored.
module snn_ff_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en_i && !empty_o;
    do_wr    = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);
    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/neg_derivative_rom_arbiter.sv
// Round-robin sharing of one registered-output neg_derivative ROM between learning lanes.
// Reads are tagged with the lane ID and returned in issue order through a credit-guarded FIFO.
module neg_derivative_rom_arbiter
  import snn_ff_pkg::*;
#(
  parameter int NUM_REQ    = NUM_LEARN_LANES,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int RSP_DEPTH  = 4,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = $clog2(RSP_DEPTH + 3) + 1;

  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  s1_vld_q, s2_vld_q;
  logic [ID_WIDTH-1:0]   s1_id_q, s2_id_q;

  logic [CW-1:0]                  fifo_count;
  logic                           fifo_empty;
  logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_rd_data;

  logic [OCC_W-1:0]    occ, occ_net;
  logic                pop, grant_ok, hs;
  logic [ID_WIDTH-1:0] grant_id, cand;

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

  // Reads already granted reserve a FIFO slot so the ROM pipe never has to stall.
  assign occ      = OCC_W'(fifo_count) + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
  assign occ_net  = occ - OCC_W'(pop);
  assign grant_ok = rst_n && (occ_net < OCC_W'(RSP_DEPTH));

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    hs        = 1'b0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!hs && grant_ok && req_valid[cand]) begin
        req_ready[cand] = 1'b1;
        grant_id        = cand;
        hs              = 1'b1;
      end
    end
    ptr_d      = hs ? grant_id : ptr_q;
    rom_addr_d = hs ? req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH] : rom_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
      rom_addr_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      s1_vld_q   <= hs;
      s1_id_q    <= grant_id;
      s2_vld_q   <= s1_vld_q;
      s2_id_q    <= s1_id_q;
    end
  end

  snn_ff_sync_fifo #(
    .WIDTH(ID_WIDTH + DATA_WIDTH),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (s2_vld_q),
    .wr_data_i({s2_id_q, rom_dout}),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rd_data),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign rom_addr = rom_addr_q;
  assign rsp_id   = fifo_rd_data[ID_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign rsp_data = fifo_rd_data[DATA_WIDTH-1:0];
  assign busy     = (occ != '0);

endmodule

// File: tb/tb_neg_derivative_rom_arbiter.sv
// Directed bench for neg_derivative_rom_arbiter with a registered-output ROM model.
module tb_neg_derivative_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_dout = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  neg_derivative_rom_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hF1;
      8'h01:   return 8'hDC;
      8'h10:   return 8'hE2;
      8'h20:   return 8'hD3;
      8'h70:   return 8'h88;
      default: return (a[3] || a[7]) ? 8'h00 : (a ^ 8'h5A);
    endcase
  endfunction

  always_ff @(posedge clk) rom_dout <= rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int lane, input logic [7:0] a);
    req_addr[lane*8 +: 8] = a;
  endtask

  task automatic single_read(input int lane, input logic [7:0] a, input logic [7:0] exp);
    set_addr(lane, a);
    req_valid = 4'b0001 << lane;
    rsp_ready = 1'b1;
    #1;
    chk("sr_ready", req_ready, 32'(4'b0001 << lane));
    tick();
    req_valid = '0;
    #1;
    chk("sr_romaddr", rom_addr, a);
    chk("sr_early1", rsp_valid, 0);
    tick();
    chk("sr_early2", rsp_valid, 0);
    chk("sr_busy", busy, 1);
    tick();
    chk("sr_valid", rsp_valid, 1);
    chk("sr_id", rsp_id, lane);
    chk("sr_data", rsp_data, exp);
    tick();
    chk("sr_after", rsp_valid, 0);
    chk("sr_idle", busy, 0);
  endtask

  logic [7:0] rr_data [4] = '{8'hDC, 8'hE2, 8'hD3, 8'h88};
  logic [7:0] bp_addr [5] = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h70};
  logic [7:0] bp_data [5] = '{8'hF1, 8'hDC, 8'hE2, 8'hD3, 8'h88};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    req_addr  = '0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_romaddr", rom_addr, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    rst_n     = 1'b1;

    // single read, then zero-region reads on lanes 3 and 2
    single_read(0, 8'h00, 8'hF1);
    single_read(3, 8'h08, 8'h00);
    single_read(2, 8'hC8, 8'h00);

    // all lanes continuously valid
    do_reset();
    set_addr(0, 8'h01);
    set_addr(1, 8'h10);
    set_addr(2, 8'h20);
    set_addr(3, 8'h70);
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk("rr_grant", req_ready, 32'(4'b0001 << (c % 4)));
      if (c >= 3) begin
        chk("rr_valid", rsp_valid, 1);
        chk("rr_id", rsp_id, (c - 3) % 4);
        chk("rr_data", rsp_data, rr_data[(c - 3) % 4]);
      end
      tick();
    end
    chk("rr_drained", rsp_valid, 0);

    // backpressure with lane 1 streaming
    do_reset();
    n = 0;
    for (int c = 0; c < 14; c++) begin
      rsp_ready = (c >= 8);
      req_valid = (c <= 8) ? 4'b0010 : 4'b0000;
      if (n < 5) set_addr(1, bp_addr[n]);
      #1;
      if (c <= 8) chk("bp_ready", req_ready, (c < 4 || c == 8) ? 32'h2 : 32'h0);
      if (c == 6 || c == 7) begin
        chk("bp_full_v", rsp_valid, 1);
        chk("bp_busy", busy, 1);
        chk("bp_head", rsp_data, 8'hF1);
      end
      if (c >= 8 && c <= 12) begin
        chk("bp_drain_v", rsp_valid, 1);
        chk("bp_drain_id", rsp_id, 1);
        chk("bp_drain_d", rsp_data, bp_data[c - 8]);
      end
      if (c == 13) begin
        chk("bp_empty", rsp_valid, 0);
        chk("bp_idle", busy, 0);
      end
      if (req_ready[1]) n++;
      tick();
    end

    // reset with three reads in flight
    do_reset();
    set_addr(0, 8'h20);
    set_addr(1, 8'h10);
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0011;
      #1;
      chk("mr_grant", req_ready, (c == 1) ? 32'h2 : 32'h1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mr_ready_in_rst", req_ready, 0);
    tick();
    chk("mr_ready", req_ready, 0);
    chk("mr_romaddr", rom_addr, 0);
    chk("mr_rspv", rsp_valid, 0);
    chk("mr_id", rsp_id, 0);
    chk("mr_data", rsp_data, 0);
    chk("mr_busy", busy, 0);
    rst_n     = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mr_no_stale", rsp_valid, 0);
      tick();
    end
    req_valid = 4'b0011;
    #1;
    chk("mr_first_lane0", req_ready, 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("mr_rsp_id", rsp_id, 0);
    chk("mr_rsp_data", rsp_data, 8'hD3);
    tick();

    // lane 2 withdraws before being granted
    do_reset();
    set_addr(1, 8'h01);
    set_addr(2, 8'h20);
    req_valid = 4'b0110;
    #1;
    chk("wd_grant1", req_ready, 32'h2);
    tick();
    req_valid = '0;
    #1;
    chk("wd_none", req_ready, 0);
    tick();
    tick();
    chk("wd_rsp_v", rsp_valid, 1);
    chk("wd_rsp_id", rsp_id, 1);
    chk("wd_rsp_d", rsp_data, 8'hDC);
    tick();
    chk("wd_no_read", rsp_valid, 0);
    chk("wd_idle", busy, 0);
    req_valid = 4'b1101;
    #1;
    chk("wd_ptr", req_ready, 32'h4);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
